gray_step_decoder: RTL



---
 rtl/gray_pkg.sv | 31 +++
 rtl/sync_bus.sv | 25 ++
 rtl/gray_step_decoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code receiver and its bench.
// Helpers work on MaxWidth-bit vectors; callers zero-extend narrower buses.
package gray_pkg;

  localparam int unsigned MaxWidth = 8;
  localparam logic [7:0] ErrCntMax = 8'd255;

  typedef enum logic [1:0] {
    StInit,
    StTrack,
    StFault
  } gray_state_e;

  // Bits at or above 'width' are masked so stray upper bits cannot leak into the decode.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g,
                                                   input int unsigned width);
    logic [MaxWidth-1:0] gm;
    logic [MaxWidth-1:0] b;
    gm = g & ((MaxWidth'(1) << width) - MaxWidth'(1));
    b[MaxWidth-1] = gm[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus; only one bit changes per step,
// so per-bit metastability resolves to either the old or the new code.
module sync_bus #(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/gray_step_decoder.sv
// Gray-bus receiver: synchronise, decode to binary, classify +/-1 steps,
// track a signed position and count illegal jumps.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned POS_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] GRAY_IN,
  input  logic             EN,
  output logic [WIDTH-1:0] BIN_OUT,
  output logic             VALID,
  output logic             STEP,
  output logic             DIR_UP,
  output logic             ERR,
  output logic [POS_W-1:0] POS,
  output logic [7:0]       ERR_CNT
);

  localparam int unsigned FillW = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0] g_sync;
  logic [WIDTH-1:0] g_prev_q;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] delta;
  logic             is_up;
  logic             is_down;
  logic             is_hold;
  logic             filled;
  logic             stable;

  gray_state_e      state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  sync_bus #(
    .Width  (WIDTH),
    .Stages (SYNC_STAGES)
  ) u_sync_bus (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (GRAY_IN),
    .q_o    (g_sync)
  );

  assign b_new   = WIDTH'(gray2bin(MaxWidth'(g_sync), WIDTH));
  assign delta   = b_new - bin_q;
  assign is_up   = (delta == WIDTH'(1));
  assign is_down = (delta == '1);
  assign is_hold = (delta == '0);
  assign stable  = (g_sync == g_prev_q);

  // INIT must not latch the reset zeros still sitting in the synchroniser.
  assign filled = (fill_q == FillW'(SYNC_STAGES));
  assign fill_d = filled ? fill_q : fill_q + FillW'(1);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    valid_d   = valid_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    err_d     = 1'b0;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;

    if (EN) begin
      unique case (state_q)
        StInit: begin
          if (filled) begin
            bin_d   = b_new;
            valid_d = 1'b1;
            state_d = StTrack;
          end
        end
        StTrack: begin
          if (is_up) begin
            bin_d  = b_new;
            step_d = 1'b1;
            dir_d  = 1'b1;
            pos_d  = pos_q + POS_W'(1);
          end else if (is_down) begin
            bin_d  = b_new;
            step_d = 1'b1;
            dir_d  = 1'b0;
            pos_d  = pos_q - POS_W'(1);
          end else if (!is_hold) begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == ErrCntMax) ? err_cnt_q : err_cnt_q + 8'd1;
            valid_d   = 1'b0;
            state_d   = StFault;
          end
        end
        StFault: begin
          // Resync only once the bus has settled for a full cycle.
          if (stable) begin
            bin_d   = b_new;
            valid_d = 1'b1;
            state_d = StTrack;
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StInit;
      fill_q    <= '0;
      g_prev_q  <= '0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      g_prev_q  <= g_sync;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign BIN_OUT = bin_q;
  assign VALID   = valid_q;
  assign STEP    = step_q;
  assign DIR_UP  = dir_q;
  assign ERR     = err_q;
  assign POS     = pos_q;
  assign ERR_CNT = err_cnt_q;

endmodule
